// File: rtl/modulation_pkg.sv
// Shared modulation definitions for the mapModulations / demapModulations
// family and their feeders: modulation codes, bytes-per-group lookup and
// group geometry constants.
package modulation_pkg;

  localparam int SYMS_PER_GROUP = 8;
  localparam int GROUP_W        = 64;

  typedef enum logic [2:0] {
    MOD_BPSK   = 3'd0,
    MOD_QPSK   = 3'd1,
    MOD_QAM16  = 3'd2,
    MOD_QAM64  = 3'd3,
    MOD_QAM256 = 3'd4
  } mod_t;

  // Packer control states: IDLE means no partial group is held.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } pack_state_t;

  // Bytes per 8-symbol group = bits per symbol of the modulation.
  function automatic logic [3:0] mod_bytes(input mod_t mod);
    logic [3:0] n;
    case (mod)
      MOD_BPSK:   n = 4'd1;
      MOD_QPSK:   n = 4'd2;
      MOD_QAM16:  n = 4'd4;
      MOD_QAM64:  n = 4'd6;
      MOD_QAM256: n = 4'd8;
      default:    n = 4'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/pack_accum.sv
// Byte-slot accumulator for symbol_group_packer. Clear has priority over
// write so a completing group always leaves an all-zero accumulator behind.
module pack_accum
  import modulation_pkg::*;
#(
  parameter int OUT_BYTES = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr_i,
  input  logic                   we_i,
  input  logic [2:0]             idx_i,
  input  logic [7:0]             byte_i,
  output logic [OUT_BYTES*8-1:0] data_o
);

  logic [OUT_BYTES*8-1:0] acc_q;

  // Slot storage: reset/clear to zero, otherwise write one byte slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= {(OUT_BYTES*8){1'b0}};
    end else if (clr_i) begin
      acc_q <= {(OUT_BYTES*8){1'b0}};
    end else if (we_i) begin
      acc_q[{idx_i, 3'b000} +: 8] <= byte_i;
    end
  end

  assign data_o = acc_q;

endmodule

// File: rtl/symbol_group_packer.sv
// symbol_group_packer: gathers N input bytes (N = bits per symbol of the
// modulation latched on the group's first byte) into one zero-padded 64-bit
// group word for the 8-symbol mapper.
// Optional feature macro: PACK_FLUSH_EN (adds a flush input that closes a
// partial group, padding the missing bytes with 0x00).
module symbol_group_packer
  import modulation_pkg::*;
#(
  parameter int         OUT_BYTES   = 8,
  parameter logic [2:0] DEFAULT_MOD = 3'd0
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef PACK_FLUSH_EN
  input  logic                   flush,
`endif
  input  logic [2:0]             mod_sel,
  input  logic [7:0]             s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [OUT_BYTES*8-1:0] m_data,
  output logic [2:0]             m_mod,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   busy
);

  localparam int DW = OUT_BYTES * 8;

  pack_state_t   state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [3:0]    nbytes_q, nbytes_d;
  logic [2:0]    mod_q, mod_d;
  logic [DW-1:0] m_data_q, m_data_d;
  logic [2:0]    m_mod_q, m_mod_d;
  logic          m_valid_q, m_valid_d;

  logic [2:0]    mod_dec_s;
  logic [3:0]    n_cur_s;
  logic          last_s, out_free_s, in_xfer_s;
  logic          acc_clr_s, acc_we_s;
  logic [DW-1:0] acc_data_s, ins_s;

`ifdef PACK_FLUSH_EN
  logic flush_pend_q, flush_pend_d, flush_req_s;
  assign flush_req_s = flush || flush_pend_q;
`endif

  // Out-of-range codes fall back to the default modulation.
  assign mod_dec_s  = (mod_sel > 3'd4) ? DEFAULT_MOD : mod_sel;
  // In IDLE the group length comes from the live mod_sel; afterwards it is latched.
  assign n_cur_s    = (state_q == ST_IDLE) ? mod_bytes(mod_t'(mod_dec_s)) : nbytes_q;
  assign last_s     = (cnt_q == (n_cur_s - 4'd1));
  assign out_free_s = !m_valid_q || m_ready;
  // Only the final byte of a group can be held back by a busy output.
  assign s_ready    = !last_s || out_free_s;
  assign in_xfer_s  = s_valid && s_ready;
  assign ins_s      = {{(DW-8){1'b0}}, s_data} << {cnt_q[2:0], 3'b000};

  pack_accum #(.OUT_BYTES(OUT_BYTES)) u_accum (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (acc_clr_s),
    .we_i   (acc_we_s),
    .idx_i  (cnt_q[2:0]),
    .byte_i (s_data),
    .data_o (acc_data_s)
  );

  // Next-state, accumulator control and output-register loading.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    nbytes_d  = nbytes_q;
    mod_d     = mod_q;
    m_data_d  = m_data_q;
    m_mod_d   = m_mod_q;
    m_valid_d = m_valid_q && !m_ready;
    acc_clr_s = 1'b0;
    acc_we_s  = 1'b0;
`ifdef PACK_FLUSH_EN
    flush_pend_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_xfer_s) begin
          mod_d    = mod_dec_s;
          nbytes_d = n_cur_s;
          if (last_s) begin
            // Single-byte group completes on its only byte.
            m_data_d  = ins_s;
            m_mod_d   = mod_dec_s;
            m_valid_d = 1'b1;
          end else begin
            acc_we_s = 1'b1;
            cnt_d    = 4'd1;
            state_d  = ST_FILL;
`ifdef PACK_FLUSH_EN
            flush_pend_d = flush;
`endif
          end
        end else begin
          cnt_d = 4'd0;
        end
      end
      ST_FILL: begin
        if (in_xfer_s) begin
          if (last_s) begin
            m_data_d  = acc_data_s | ins_s;
            m_mod_d   = mod_q;
            m_valid_d = 1'b1;
            acc_clr_s = 1'b1;
            cnt_d     = 4'd0;
            state_d   = ST_IDLE;
          end else begin
            acc_we_s = 1'b1;
            cnt_d    = cnt_q + 4'd1;
`ifdef PACK_FLUSH_EN
            flush_pend_d = flush_req_s;
`endif
          end
`ifdef PACK_FLUSH_EN
        end else if (flush_req_s) begin
          if (out_free_s) begin
            // Missing bytes are already zero in the accumulator.
            m_data_d  = acc_data_s;
            m_mod_d   = mod_q;
            m_valid_d = 1'b1;
            acc_clr_s = 1'b1;
            cnt_d     = 4'd0;
            state_d   = ST_IDLE;
          end else begin
            flush_pend_d = 1'b1;
          end
`endif
        end else begin
          state_d = ST_FILL;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        cnt_d     = 4'd0;
        acc_clr_s = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      nbytes_q  <= 4'd1;
      mod_q     <= DEFAULT_MOD;
      m_data_q  <= {DW{1'b0}};
      m_mod_q   <= DEFAULT_MOD;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      nbytes_q  <= nbytes_d;
      mod_q     <= mod_d;
      m_data_q  <= m_data_d;
      m_mod_q   <= m_mod_d;
      m_valid_q <= m_valid_d;
    end
  end

`ifdef PACK_FLUSH_EN
  // Pending flush request carried past an accepted non-final byte or a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_pend_q <= 1'b0;
    end else begin
      flush_pend_q <= flush_pend_d;
    end
  end
`endif

  assign m_data  = m_data_q;
  assign m_mod   = m_mod_q;
  assign m_valid = m_valid_q;
  assign busy    = (cnt_q != 4'd0);

endmodule

// File: tb/tb_symbol_group_packer.sv
// Testbench for symbol_group_packer: directed scenarios with fixed expected
// words plus a long randomized run checked every cycle against a queue-based
// reference model of the group-building rules.
module tb_symbol_group_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  mod_sel;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic [63:0] m_data;
  logic [2:0]  m_mod;
  logic        m_valid;
  logic        m_ready;
  logic        busy;
`ifdef PACK_FLUSH_EN
  logic        flush = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  symbol_group_packer dut (
    .clk     (clk),
    .rst     (rst),
`ifdef PACK_FLUSH_EN
    .flush   (flush),
`endif
    .mod_sel (mod_sel),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .m_data  (m_data),
    .m_mod   (m_mod),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .busy    (busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int n_of(input logic [2:0] m);
    case (m)
      3'd1:    return 2;
      3'd2:    return 4;
      3'd3:    return 6;
      3'd4:    return 8;
      default: return 1;   // BPSK and invalid codes (default modulation is BPSK)
    endcase
  endfunction

  function automatic logic [2:0] dec(input logic [2:0] m);
    return (m > 3'd4) ? 3'd0 : m;
  endfunction

  logic [7:0]  mq[$];      // bytes of the group being collected
  int          cur_n;
  logic [2:0]  cur_mod;
  logic        ev;         // expected m_valid
  logic [63:0] ed;         // expected m_data
  logic [2:0]  em;         // expected m_mod

  // Compare before each rising edge, then advance the model across that edge.
  always @(negedge clk) begin
    int          n_eff;
    logic        er;
    logic [63:0] g;
    if (rst) begin
      mq.delete();
      ev = 1'b0; ed = 64'd0; em = 3'd0; cur_n = 1; cur_mod = 3'd0;
    end else begin
      n_eff = (mq.size() == 0) ? n_of(mod_sel) : cur_n;
      er = (mq.size() != n_eff - 1) || !ev || m_ready;
      check_eq("s_ready", {63'd0, s_ready}, {63'd0, er});
      check_eq("m_valid", {63'd0, m_valid}, {63'd0, ev});
      check_eq("busy",    {63'd0, busy},    {63'd0, (mq.size() != 0)});
      check_eq("m_data",  m_data, ed);
      check_eq("m_mod",   {61'd0, m_mod},   {61'd0, em});
      if (s_valid && er) begin
        if (mq.size() == 0) begin
          cur_n   = n_eff;
          cur_mod = dec(mod_sel);
        end
        mq.push_back(s_data);
        if (mq.size() == cur_n) begin
          g = 64'd0;
          for (int k = 0; k < mq.size(); k++) g = g | (64'(mq[k]) << (8 * k));
          ed = g; em = cur_mod; ev = 1'b1;
          mq.delete();
        end else if (ev && m_ready) begin
          ev = 1'b0;
        end
      end else if (ev && m_ready) begin
        ev = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [7:0] d, input logic [2:0] ms, input logic mr);
    bit ok = 1'b0;
    s_valid = 1'b1; s_data = d; mod_sel = ms; m_ready = mr;
    #1;
    for (int i = 0; i < 64; i++) begin
      if (s_ready) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!ok) check_eq("send_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic idle_cycle(input logic mr);
    s_valid = 1'b0; m_ready = mr;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; mod_sel = 3'd0; s_data = 8'd0; s_valid = 1'b0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check_eq("rst_s_ready", {63'd0, s_ready}, 64'd1);
    check_eq("rst_m_valid", {63'd0, m_valid}, 64'd0);
    check_eq("rst_m_data",  m_data, 64'd0);
    check_eq("rst_m_mod",   {61'd0, m_mod}, 64'd0);
    check_eq("rst_busy",    {63'd0, busy}, 64'd0);
    @(posedge clk); #1;

    // BPSK back-to-back with m_ready high
    send(8'hA5, 3'd0, 1'b1);
    check_eq("bpsk0_data", m_data, 64'h0000_0000_0000_00A5);
    check_eq("bpsk0_valid", {63'd0, m_valid}, 64'd1);
    send(8'h3C, 3'd0, 1'b1);
    check_eq("bpsk1_data", m_data, 64'h0000_0000_0000_003C);
    check_eq("bpsk1_mod", {61'd0, m_mod}, 64'd0);
    idle_cycle(1'b1);
    check_eq("bpsk_drain", {63'd0, m_valid}, 64'd0);

    // QAM64 0x01..0x06
    for (int i = 1; i <= 5; i++) send(8'(i), 3'd3, 1'b0);
    check_eq("qam64_early", {63'd0, m_valid}, 64'd0);
    send(8'h06, 3'd3, 1'b0);
    check_eq("qam64_valid", {63'd0, m_valid}, 64'd1);
    check_eq("qam64_data", m_data, 64'h0000_0605_0403_0201);
    check_eq("qam64_mod", {61'd0, m_mod}, 64'd3);
    idle_cycle(1'b1);

    // mod_sel changes mid-group: QAM16 group stays 4 bytes, next QPSK group clean
    send(8'h11, 3'd2, 1'b0);
    send(8'h22, 3'd2, 1'b0);
    send(8'h33, 3'd1, 1'b0);
    send(8'h44, 3'd1, 1'b0);
    check_eq("chg_q16_data", m_data, 64'h0000_0000_4433_2211);
    check_eq("chg_q16_mod", {61'd0, m_mod}, 64'd2);
    send(8'h55, 3'd1, 1'b1);
    send(8'h66, 3'd1, 1'b1);
    check_eq("chg_qpsk_data", m_data, 64'h0000_0000_0000_6655);
    check_eq("chg_qpsk_mod", {61'd0, m_mod}, 64'd1);
    idle_cycle(1'b1);

    // reset with a pending output and a partial QAM64 group
    send(8'h77, 3'd0, 1'b0);
    for (int i = 0; i < 3; i++) send(8'hE0 + 8'(i), 3'd3, 1'b0);
    check_eq("pre_rst_busy", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    #1;
    check_eq("mid_rst_busy", {63'd0, busy}, 64'd0);
    check_eq("mid_rst_valid", {63'd0, m_valid}, 64'd0);
    check_eq("mid_rst_data", m_data, 64'd0);
    for (int i = 1; i <= 6; i++) send(8'hA0 + 8'(i), 3'd3, 1'b0);
    check_eq("post_rst_data", m_data, 64'h0000_A6A5_A4A3_A2A1);
    idle_cycle(1'b1);

    // randomized run; the model checks every cycle
    for (int c = 0; c < 6000; c++) begin
      rst     = ($urandom_range(0, 499) == 0);
      s_valid = ($urandom_range(0, 3) != 0);
      s_data  = 8'($urandom);
      mod_sel = 3'($urandom_range(0, 7));
      case ((c / 500) % 3)
        0:       m_ready = 1'b1;
        1:       m_ready = ($urandom_range(0, 3) == 0);
        default: m_ready = ($urandom_range(0, 1) == 0);
      endcase
      @(posedge clk); #1;
    end
    rst = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
